btn_debounce_multi: RTL and testbench
=====================================

// Module: btn_debounce_multi
// PURPOSE
//  N-channel push-button and rotary-centre debouncer. It replaces the single shared-timer debouncer.
//  Each channel has its own synchroniser, its own stability counter and its own stable level.
//  Each channel emits one-cycle press and release pulses, and optionally auto-repeat press pulses while held.
//  Sits between the board button pins and the LCD/menu control logic.
// PARAMETERS
//  N             5        number of channels (1..32)
//  DB_CYCLES     1000000  consecutive stable cycles required to accept a change (>=2); 20 ms at 50 MHz
//  REPEAT_EN     0        1 = auto-repeat press pulses while a channel is held
//  REPEAT_DLY    25000000 cycles from accepted press to first repeat pulse (>=1)
//  REPEAT_PERIOD 5000000  cycles between subsequent repeat pulses (>=1)
// PORTS
//  clk       in   1  system clock
//  rst       in   1  asynchronous, active-high reset
//  btn_in    in   N  raw asynchronous button inputs, active-high
//  level     out  N  debounced stable level per channel
//  press     out  N  one-cycle pulse on accepted press, and on each repeat tick
//  release   out  N  one-cycle pulse on accepted release
//  rpt       out  N  one-cycle pulse, asserted together with press only for repeat ticks
// BEHAVIOUR
//  Reset (async): sync flops, counters, level, press, release and rpt all clear to 0.
//  Synchroniser: 2-flop per channel; s = btn_in delayed 2 edges. No logic reads btn_in directly.
//  Per-channel debounce counter:
//   - width = $clog2(DB_CYCLES+1).
//   - If s == level: counter <= 0.
//   - If s != level: counter increments.
//   - When counter == DB_CYCLES-1 and s != level: level <= s, counter <= 0.
//   - On that edge, press (s=1) or release (s=0) is registered and valid the following cycle.
//  Latency: btn_in stable high from edge E means level=1 and press=1 after edge E+2+DB_CYCLES.
//   Release has the same latency. press and release are high for exactly 1 cycle.
//  Glitch rejection: any s==level cycle before terminal count restarts the count from 0. No pulse.
//  Channels are fully independent:
//   - Simultaneous changes on several channels each produce their own pulse.
//   - Pulses can coincide in the same cycle on different bits.
//  Per-channel repeat FSM (present only when REPEAT_EN=1; otherwise rpt=0 and press fires only on acceptance):
//   IDLE   : level=0. Accepted press -> ARMED, rcnt<=0.
//   ARMED  : rcnt counts. When rcnt==REPEAT_DLY-1: press=1, rpt=1, rcnt<=0 -> REPEAT.
//   REPEAT : rcnt counts. When rcnt==REPEAT_PERIOD-1: press=1, rpt=1, rcnt<=0.
//   Accepted release in ARMED or REPEAT -> IDLE, rcnt<=0, release pulse. No repeat pulse that same cycle.
//  Repeat counter width = $clog2(max(REPEAT_DLY,REPEAT_PERIOD)+1). The counter never wraps; it is cleared at terminal count.
//  Reset mid-count or mid-hold: everything clears immediately.
//   A button still held after reset deassert is re-debounced and yields a fresh press after 2+DB_CYCLES edges.
//  level never changes without a corresponding press or release pulse. press and release are never both high on one bit.
// TESTING (bench with N=3, DB_CYCLES=4, REPEAT_EN=1, REPEAT_DLY=8, REPEAT_PERIOD=3)
//  1. Clean press: btn_in[0] 0->1 held. Required:
//     - press[0] and level[0] rise exactly 6 edges later; press[0] width 1.
//     - No pulse on bits 1 and 2.
//  2. Bounce: btn_in[1] pattern 1,0,1,1,0 (1 cycle each) then 1 held. Required:
//     - No pulse during the bounce.
//     - Single press[1] 6 edges after the final rise.
//     - Release with the same bounce gives a single release[1].
//  3. Auto-repeat: hold btn_in[2] high for 40 cycles after acceptance. Required:
//     - Repeat press[2]+rpt[2] at 8 cycles after acceptance, then every 3 cycles.
//     - Release: release[2] once; no further repeats.
//  4. Simultaneous: btn_in=3'b111 on the same edge. Required:
//     - press=3'b111 in one cycle; rpt=0.
//     - Dropping to 3'b000 gives release=3'b111 in one cycle.
//  5. Reset mid-operation: assert rst while level[0]=1 and in REPEAT; keep btn_in[0]=1. Required:
//     - All outputs 0 immediately.
//     - After deassert: new press[0] 6 edges later, first repeat after 8 more cycles.
//  6. Sub-threshold pulse: btn_in[0] high for 3 cycles only. Required:
//     - level, press, release and rpt stay 0 throughout.

Source files
------------

// File: rtl/btn_debounce_multi.sv
// N-channel button debouncer: per-channel 2-flop sync, stability counter,
// press/release pulses and optional auto-repeat.
module btn_debounce_multi #(
  parameter int N             = 5,
  parameter int DB_CYCLES     = 1000000,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DLY    = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn_in,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] rel,
  output logic [N-1:0] rpt
);

  localparam int CW   = $clog2(DB_CYCLES + 1);
  localparam int RMAX = (REPEAT_DLY > REPEAT_PERIOD) ?
                        REPEAT_DLY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    REPEAT = 2'd2
  } rpt_st_e;

  logic [N-1:0]  meta_q, meta_d;
  logic [N-1:0]  sync_q, sync_d;
  logic [N-1:0]  lvl_q, lvl_d;
  logic [N-1:0]  press_q, press_d;
  logic [N-1:0]  rel_q, rel_d;
  logic [N-1:0]  rpt_q, rpt_d;
  logic [N-1:0]  acc;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];
  logic [RW-1:0] rcnt_q [N];
  logic [RW-1:0] rcnt_d [N];
  rpt_st_e       st_q [N];
  rpt_st_e       st_d [N];

  always_comb begin
    meta_d  = btn_in;
    sync_d  = meta_q;
    lvl_d   = lvl_q;
    press_d = '0;
    rel_d   = '0;
    rpt_d   = '0;
    acc     = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i]  = cnt_q[i];
      rcnt_d[i] = rcnt_q[i];
      st_d[i]   = st_q[i];
      if (sync_q[i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CW'(DB_CYCLES - 1)) begin
        cnt_d[i]   = '0;
        lvl_d[i]   = sync_q[i];
        acc[i]     = 1'b1;
        press_d[i] = sync_q[i];
        rel_d[i]   = ~sync_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
      // An accepted release always wins over a coincident repeat tick.
      if (REPEAT_EN != 0) begin
        unique case (st_q[i])
          IDLE: begin
            if (acc[i] && sync_q[i]) begin
              st_d[i]   = ARMED;
              rcnt_d[i] = '0;
            end
          end
          ARMED: begin
            if (acc[i]) begin
              st_d[i]   = IDLE;
              rcnt_d[i] = '0;
            end else if (rcnt_q[i] == RW'(REPEAT_DLY - 1)) begin
              st_d[i]    = REPEAT;
              rcnt_d[i]  = '0;
              press_d[i] = 1'b1;
              rpt_d[i]   = 1'b1;
            end else begin
              rcnt_d[i] = rcnt_q[i] + 1'b1;
            end
          end
          REPEAT: begin
            if (acc[i]) begin
              st_d[i]   = IDLE;
              rcnt_d[i] = '0;
            end else if (rcnt_q[i] == RW'(REPEAT_PERIOD - 1)) begin
              rcnt_d[i]  = '0;
              press_d[i] = 1'b1;
              rpt_d[i]   = 1'b1;
            end else begin
              rcnt_d[i] = rcnt_q[i] + 1'b1;
            end
          end
          default: begin
            st_d[i]   = IDLE;
            rcnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q  <= '0;
      sync_q  <= '0;
      lvl_q   <= '0;
      press_q <= '0;
      rel_q   <= '0;
      rpt_q   <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i]  <= '0;
        rcnt_q[i] <= '0;
        st_q[i]   <= IDLE;
      end
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      lvl_q   <= lvl_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      rpt_q   <= rpt_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i]  <= cnt_d[i];
        rcnt_q[i] <= rcnt_d[i];
        st_q[i]   <= st_d[i];
      end
    end
  end

  assign level = lvl_q;
  assign press = press_q;
  assign rel   = rel_q;
  assign rpt   = rpt_q;

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: directed scenarios plus random bouncing,
// all checked cycle by cycle against a behavioural model.
module tb_btn_debounce_multi;

  localparam int N   = 3;
  localparam int DB  = 4;
  localparam int DLY = 8;
  localparam int PER = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] level, press, rel, rpt;

  int n_chk  = 0;
  int n_fail = 0;

  btn_debounce_multi #(
    .N(N), .DB_CYCLES(DB), .REPEAT_EN(1),
    .REPEAT_DLY(DLY), .REPEAT_PERIOD(PER)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .level(level), .press(press), .rel(rel), .rpt(rpt)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [N-1:0] act, logic [N-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: s is the input seen two edges ago; a change is accepted after
  // DB consecutive differing samples; repeats at age DLY, DLY+k*PER.
  logic [N-1:0] p1, p2, ml, ep, er, erp;
  int           run [N];
  int           age [N];
  bit           held [N];

  initial begin
    p1 = '0; p2 = '0; ml = '0; ep = '0; er = '0; erp = '0;
    for (int i = 0; i < N; i++) begin
      run[i] = 0; age[i] = 0; held[i] = 0;
    end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        p1 = '0; p2 = '0; ml = '0; ep = '0; er = '0; erp = '0;
        for (int i = 0; i < N; i++) begin
          run[i] = 0; age[i] = 0; held[i] = 0;
        end
      end else begin
        for (int i = 0; i < N; i++) begin
          logic s;
          bit   a;
          s = p2[i];
          p2[i] = p1[i];
          p1[i] = btn_in[i];
          ep[i] = 0; er[i] = 0; erp[i] = 0; a = 0;
          if (s !== ml[i]) begin
            run[i]++;
            if (run[i] == DB) begin
              a = 1; ml[i] = s; run[i] = 0;
              if (s) begin
                ep[i] = 1; held[i] = 1; age[i] = 0;
              end else begin
                er[i] = 1; held[i] = 0;
              end
            end
          end else begin
            run[i] = 0;
          end
          if (!a && held[i]) begin
            age[i]++;
            if (age[i] == DLY ||
                (age[i] > DLY && (age[i] - DLY) % PER == 0)) begin
              ep[i] = 1; erp[i] = 1;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_level", level, ml);
      chk("model_press", press, ep);
      chk("model_release", rel, er);
      chk("model_rpt", rpt, erp);
      n_chk++;
      if ((press & rel) != '0) begin
        n_fail++;
        $display("FAIL press_and_release: press %b release %b", press, rel);
      end
    end
  end

  task automatic wn(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drv(logic [N-1:0] v);
    #1 btn_in = v;
  endtask

  logic [N-1:0] acc_o;
  logic [N-1:0] v;

  initial begin
    wn(3);
    chk("reset_level", level, 3'b000);
    chk("reset_press", press, 3'b000);
    #1 rst = 1'b0;
    wn(2);

    // 1: clean press, repeat, release suppressing coincident repeat
    drv(3'b001);
    wn(5); chk("t1_early", press, 3'b000);
    wn(1); chk("t1_press", press, 3'b001);
    chk("t1_level", level, 3'b001);
    wn(1); chk("t1_width", press, 3'b000);
    wn(7); chk("t1_rpt", rpt, 3'b001);
    chk("t1_rpt_press", press, 3'b001);
    drv(3'b000);
    wn(6); chk("t1_release", rel, 3'b001);
    chk("t1_no_rpt", rpt, 3'b000);
    chk("t1_no_press", press, 3'b000);
    wn(5);

    // 2: bounce on channel 1
    foreach (v[k]) v[k] = 1'b0;
    begin
      logic [5:0] pat;
      pat = 6'b101101;
      for (int k = 5; k >= 0; k--) begin
        wn(1); drv({1'b0, pat[k], 1'b0});
      end
      wn(6); chk("t2_press", press, 3'b010);
      pat = 6'b010010;
      for (int k = 5; k >= 0; k--) begin
        wn(1); drv({1'b0, pat[k], 1'b0});
      end
      wn(6); chk("t2_release", rel, 3'b010);
    end
    wn(5);

    // 3: long hold on channel 2
    drv(3'b100);
    wn(6); chk("t3_press", press, 3'b100);
    wn(8); chk("t3_rpt1", rpt, 3'b100);
    wn(3); chk("t3_rpt2", rpt, 3'b100);
    wn(29);
    drv(3'b000);
    wn(6); chk("t3_release", rel, 3'b100);
    acc_o = '0;
    repeat (12) begin
      wn(1); acc_o |= rpt | press;
    end
    chk("t3_quiet", acc_o, 3'b000);

    // 4: simultaneous
    drv(3'b111);
    wn(6); chk("t4_press", press, 3'b111);
    chk("t4_rpt", rpt, 3'b000);
    wn(1); drv(3'b000);
    wn(6); chk("t4_release", rel, 3'b111);
    wn(5);

    // 5: reset while repeating
    drv(3'b001);
    wn(6); chk("t5_press0", press, 3'b001);
    wn(8); chk("t5_rpt0", rpt, 3'b001);
    wn(1);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_level", level, 3'b000);
    chk("t5_rst_press", press | rel | rpt, 3'b000);
    wn(1);
    #1 rst = 1'b0;
    wn(5); chk("t5_early", press, 3'b000);
    wn(1); chk("t5_press", press, 3'b001);
    wn(8); chk("t5_rpt", rpt, 3'b001);
    drv(3'b000);
    wn(10);

    // 6: sub-threshold pulse
    acc_o = '0;
    drv(3'b001);
    repeat (3) begin
      wn(1); acc_o |= level | press | rel | rpt;
    end
    drv(3'b000);
    repeat (12) begin
      wn(1); acc_o |= level | press | rel | rpt;
    end
    chk("t6_quiet", acc_o, 3'b000);

    // random bouncing, checked by the model
    repeat (2000) begin
      wn(1);
      v = btn_in;
      if ($urandom_range(0, 3) == 0)
        v[$urandom_range(0, N - 1)] ^= 1'b1;
      drv(v);
    end
    drv(3'b000);
    wn(20);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
